// File: rtl/alu_muldiv_unit_pkg.sv
// Shared op and state encodings for the iterative multiply/divide unit.
// Ops 000 (NOP) and 111 (reserved) have no constant: every unmatched op is a no-op.
package alu_muldiv_unit_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_OP_MULT  = 3'b001;
  localparam md_op_t MD_OP_MULTU = 3'b010;
  localparam md_op_t MD_OP_DIV   = 3'b011;
  localparam md_op_t MD_OP_DIVU  = 3'b100;
  localparam md_op_t MD_OP_MTHI  = 3'b101;
  localparam md_op_t MD_OP_MTLO  = 3'b110;

  localparam logic [1:0] MD_ST_IDLE = 2'd0;
  localparam logic [1:0] MD_ST_CALC = 2'd1;
  localparam logic [1:0] MD_ST_FIX  = 2'd2;

  function automatic logic md_is_arith(md_op_t op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) || (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic md_is_div(md_op_t op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic md_is_signed(md_op_t op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_unit_if.sv
// EX-stage request/response bundle for the multiply/divide unit.
interface alu_muldiv_unit_if #(parameter int DATA_W = 32);
  import alu_muldiv_unit_pkg::*;

  logic              start_i;
  md_op_t            op_i;
  logic [DATA_W-1:0] a_i;
  logic [DATA_W-1:0] b_i;
  logic              flush_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              divz_o;

  modport master (output start_i, op_i, a_i, b_i, flush_i,
                  input  busy_o, done_o, hi_o, lo_o, divz_o);
  modport slave  (input  start_i, op_i, a_i, b_i, flush_i,
                  output busy_o, done_o, hi_o, lo_o, divz_o);
endinterface

// File: rtl/alu_muldiv_unit_step.sv
// One radix-2 iteration on the {acc, q} pair: shift-add for multiply, restoring
// shift-subtract for divide.
module alu_muldiv_unit_step #(
  parameter int DATA_W = 32
) (
  input  logic              div_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [DATA_W-1:0] opb_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic            fits;

  always_comb begin
    sum     = {1'b0, acc_i} + (q_i[0] ? {1'b0, opb_i} : '0);
    shifted = {acc_i, q_i[DATA_W-1]};
    fits    = (shifted >= {1'b0, opb_i});
    if (div_i) begin
      // partial remainder stays below the divisor, so the difference fits in DATA_W bits
      acc_o = fits ? (shifted[DATA_W-1:0] - opb_i) : shifted[DATA_W-1:0];
      q_o   = {q_i[DATA_W-2:0], fits};
    end else begin
      acc_o = sum[DATA_W:1];
      q_o   = {sum[0], q_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; also handles MTHI/MTLO.
// Optional MULDIV_DIVZERO_TRAP_EN: divide by zero pulses divz_o instead of iterating.
module alu_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_muldiv_unit_if.slave   md_if
);
  import alu_muldiv_unit_pkg::*;

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d, q_q, q_d, opb_q, opb_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              div_q, div_d, sgn_quo_q, sgn_quo_d, sgn_rem_q, sgn_rem_d;
  logic              done_q, done_d, divz_q, divz_d;
  logic [DATA_W-1:0] acc_s, q_s, a_mag, b_mag;
  logic              a_neg, b_neg;

  alu_muldiv_unit_step #(.DATA_W(DATA_W)) u_step (
    .div_i (div_q),
    .acc_i (acc_q),
    .q_i   (q_q),
    .opb_i (opb_q),
    .acc_o (acc_s),
    .q_o   (q_s)
  );

  always_comb begin
    a_neg     = md_is_signed(md_if.op_i) & md_if.a_i[DATA_W-1];
    b_neg     = md_is_signed(md_if.op_i) & md_if.b_i[DATA_W-1];
    a_mag     = a_neg ? -md_if.a_i : md_if.a_i;
    b_mag     = b_neg ? -md_if.b_i : md_if.b_i;
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    opb_d     = opb_q;
    div_d     = div_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divz_d    = 1'b0;
    case (state_q)
      MD_ST_IDLE: begin
        if (md_if.start_i && !md_if.flush_i) begin
          if (md_is_arith(md_if.op_i)) begin
`ifdef MULDIV_DIVZERO_TRAP_EN
            if (md_is_div(md_if.op_i) && (md_if.b_i == '0)) begin
              done_d = 1'b1;
              divz_d = 1'b1;
            end else begin
`endif
              state_d   = MD_ST_CALC;
              cnt_d     = CNT_W'(DATA_W - 1);
              acc_d     = '0;
              q_d       = a_mag;
              opb_d     = b_mag;
              div_d     = md_is_div(md_if.op_i);
              sgn_quo_d = a_neg ^ b_neg;
              sgn_rem_d = a_neg;
`ifdef MULDIV_DIVZERO_TRAP_EN
            end
`endif
          end else if (md_if.op_i == MD_OP_MTHI) begin
            hi_d = md_if.a_i;
          end else if (md_if.op_i == MD_OP_MTLO) begin
            lo_d = md_if.a_i;
          end
        end
      end
      MD_ST_CALC: begin
        if (md_if.flush_i) begin
          state_d = MD_ST_IDLE;
        end else begin
          acc_d = acc_s;
          q_d   = q_s;
          if (cnt_q == '0) state_d = MD_ST_FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      MD_ST_FIX: begin
        state_d = MD_ST_IDLE;
        if (!md_if.flush_i) begin
          done_d = 1'b1;
          if (div_q) begin
            lo_d = sgn_quo_q ? -q_q : q_q;
            hi_d = sgn_rem_q ? -acc_q : acc_q;
          end else begin
            {hi_d, lo_d} = sgn_quo_q ? -{acc_q, q_q} : {acc_q, q_q};
          end
        end
      end
      default: state_d = MD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      opb_q     <= '0;
      div_q     <= 1'b0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      opb_q     <= opb_d;
      div_q     <= div_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divz_q    <= divz_d;
    end
  end

  assign md_if.busy_o = (state_q != MD_ST_IDLE);
  assign md_if.done_o = done_q;
  assign md_if.hi_o   = hi_q;
  assign md_if.lo_o   = lo_q;
  assign md_if.divz_o = divz_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed-vector bench for alu_muldiv_unit at DATA_W=32, both divide-by-zero builds.
module tb_alu_muldiv_unit;
  import alu_muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  alu_muldiv_unit_if #(.DATA_W(32)) md_if ();

  alu_muldiv_unit #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md_if (md_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    md_if.start_i = 1'b1;
    md_if.op_i    = op;
    md_if.a_i     = a;
    md_if.b_i     = b;
    tick();
    md_if.start_i = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (md_if.done_o !== 1'b1 && lat < 200) begin
      if (md_if.busy_o === 1'b1) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat, bcnt;
    issue(op, a, b);
    wait_done(lat, bcnt);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_hi"}, 64'(md_if.hi_o), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(md_if.lo_o), 64'(exp_lo));
    chk({tag, "_busy_at_done"}, 64'(md_if.busy_o), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, 64'(md_if.done_o), 64'd0);
  endtask

  initial begin
    int lat, bcnt, seen;
    md_if.start_i = 1'b0;
    md_if.op_i    = 3'b000;
    md_if.a_i     = '0;
    md_if.b_i     = '0;
    md_if.flush_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 64'(md_if.busy_o), 64'd0);
    chk("rst_done", 64'(md_if.done_o), 64'd0);
    chk("rst_divz", 64'(md_if.divz_o), 64'd0);
    chk("rst_hi", 64'(md_if.hi_o), 64'd0);
    chk("rst_lo", 64'(md_if.lo_o), 64'd0);

    issue(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_busy_cycles", 64'(bcnt), 64'd33);
    chk("multu_hi", 64'(md_if.hi_o), 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo", 64'(md_if.lo_o), 64'h0000_0000_0000_0001);
    tick();
    chk("multu_done_pulse", 64'(md_if.done_o), 64'd0);

    do_op("mult_neg", MD_OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("mult_minmin", MD_OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    do_op("div_m7_2", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_7_m2", MD_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    do_op("div_min_m1", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    do_op("divu_100_7", MD_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

`ifdef MULDIV_DIVZERO_TRAP_EN
    issue(MD_OP_DIVU, 32'd100, 32'd0);
    chk("divz_pulse", 64'(md_if.divz_o), 64'd1);
    chk("divz_done", 64'(md_if.done_o), 64'd1);
    chk("divz_busy", 64'(md_if.busy_o), 64'd0);
    chk("divz_hi", 64'(md_if.hi_o), 64'd2);
    chk("divz_lo", 64'(md_if.lo_o), 64'd14);
    tick();
    chk("divz_pulse_end", 64'(md_if.divz_o), 64'd0);
`else
    do_op("divu_zero", MD_OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    chk("divz_tied", 64'(md_if.divz_o), 64'd0);
`endif

    issue(MD_OP_MTHI, 32'hCAFE_0000, 32'h0);
    chk("mthi_hi", 64'(md_if.hi_o), 64'h0000_0000_CAFE_0000);
    chk("mthi_busy", 64'(md_if.busy_o), 64'd0);
    issue(MD_OP_MTLO, 32'h0000_BEEF, 32'h0);
    chk("mtlo_lo", 64'(md_if.lo_o), 64'h0000_0000_0000_BEEF);
    issue(3'b111, 32'h1111_1111, 32'h2);
    chk("rsvd_hi", 64'(md_if.hi_o), 64'h0000_0000_CAFE_0000);
    chk("rsvd_lo", 64'(md_if.lo_o), 64'h0000_0000_0000_BEEF);
    chk("rsvd_busy", 64'(md_if.busy_o), 64'd0);

    md_if.flush_i = 1'b1;
    issue(MD_OP_MTHI, 32'h5555_5555, 32'h0);
    md_if.flush_i = 1'b0;
    chk("flush_idle_hi", 64'(md_if.hi_o), 64'h0000_0000_CAFE_0000);

    issue(MD_OP_MULT, 32'd5, 32'd6);
    repeat (9) tick();
    md_if.flush_i = 1'b1;
    tick();
    md_if.flush_i = 1'b0;
    chk("flush_busy", 64'(md_if.busy_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_if.done_o === 1'b1) seen++;
      tick();
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_hi", 64'(md_if.hi_o), 64'h0000_0000_CAFE_0000);
    chk("flush_lo", 64'(md_if.lo_o), 64'h0000_0000_0000_BEEF);
    issue(MD_OP_MTLO, 32'h0000_1234, 32'h0);
    chk("mtlo2_lo", 64'(md_if.lo_o), 64'h0000_0000_0000_1234);
    chk("mtlo2_busy", 64'(md_if.busy_o), 64'd0);

    issue(MD_OP_DIV, 32'd1000, 32'd3);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(md_if.busy_o), 64'd0);
    chk("arst_hi", 64'(md_if.hi_o), 64'd0);
    chk("arst_lo", 64'(md_if.lo_o), 64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_stays_idle", 64'(md_if.busy_o), 64'd0);

    issue(MD_OP_MULTU, 32'd3, 32'd5);
    repeat (5) tick();
    issue(MD_OP_DIVU, 32'd9, 32'd2);
    md_if.a_i = 32'hDEAD_BEEF;
    md_if.b_i = 32'h1234_5678;
    wait_done(lat, bcnt);
    chk("busy_start_lat", 64'(lat), 64'd27);
    chk("busy_start_hi", 64'(md_if.hi_o), 64'd0);
    chk("busy_start_lo", 64'(md_if.lo_o), 64'd15);
    tick();
    chk("busy_start_no_second", 64'(md_if.busy_o), 64'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
